// File: rtl/reg_req_sched_if.sv
// Producer-side request/response bundle for reg_req_sched.
// The scheduler takes the slave modport; producers or benches take the master modport.
interface reg_req_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) ();
  // Handshake: a request transfers on every rising edge where req_valid && req_ready.
  // Once req_valid is raised, the producer holds req_we/req_addr/req_wdata stable until
  // that transfer occurs. req_ready never depends on req_valid. rsp_valid is a one-cycle
  // strobe with no back-pressure.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_addr, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_addr, rsp_data
  );
endinterface

// File: rtl/reg_req_sched.sv
// In-order request scheduler and sole driver of the 16x32 register file port.
// Optional build macro REG_REQ_FWD_EN: reads that hit the last issued write are served from a record.
module reg_req_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  reg_req_sched_if.slave    bus,
  output logic              rf_read_en,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RD_WAIT = 2'd2} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_count;
  state_t            r_state, w_state_nxt;

  logic              r_rf_re, r_rf_we;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_full, w_empty, w_ready, w_push, w_pop, w_can_pop;
  logic              w_rf_re_nxt, w_rf_we_nxt, w_rsp_cap, w_fwd_hit;
  logic [ADDR_W-1:0] w_rsp_addr_sel;
  logic [DATA_W-1:0] w_rsp_data_sel;
  entry_t            w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_ready = !w_full && !flush;
  assign w_push  = bus.req_valid && w_ready;
  assign w_head  = r_mem[r_rd_ptr];

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_addr  = r_rsp_addr;
  assign bus.rsp_data  = r_rsp_data;
  assign rf_read_en    = r_rf_re;
  assign rf_write_en   = r_rf_we;
  assign rf_addr       = r_rf_addr;
  assign rf_write_data = r_rf_wdata;
  assign busy          = !w_empty || (r_state != S_IDLE);
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A read leaves ISSUE without popping so the port stays reserved for its data cycle;
  // RD_WAIT and ISSUE(write) both accept the next entry directly.
  always_comb begin
    w_state_nxt = r_state;
    w_can_pop   = 1'b0;
    w_pop       = 1'b0;
    w_rf_re_nxt = 1'b0;
    w_rf_we_nxt = 1'b0;
    w_rsp_cap   = 1'b0;
    case (r_state)
      S_IDLE:    w_can_pop = 1'b1;
      S_ISSUE:   if (r_rf_we) w_can_pop = 1'b1;
                 else         w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        w_rsp_cap = 1'b1;
        w_can_pop = 1'b1;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_can_pop) begin
      if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = S_ISSUE;
        w_rf_we_nxt = w_head.we;
        w_rf_re_nxt = !w_head.we && !w_fwd_hit;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_pop       = 1'b0;
      w_rf_re_nxt = 1'b0;
      w_rf_we_nxt = 1'b0;
      w_rsp_cap   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rf_re     <= 1'b0;
      r_rf_we     <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_wdata  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rf_re     <= w_rf_re_nxt;
      r_rf_we     <= w_rf_we_nxt;
      r_rsp_valid <= w_rsp_cap;
      if (w_rf_re_nxt || w_rf_we_nxt) r_rf_addr <= w_head.addr;
      if (w_rf_we_nxt) r_rf_wdata <= w_head.wdata;
      if (w_rsp_cap) begin
        r_rsp_addr <= w_rsp_addr_sel;
        r_rsp_data <= w_rsp_data_sel;
      end
    end
  end

`ifdef REG_REQ_FWD_EN
  logic              r_rec_v, r_fwd_pend;
  logic [ADDR_W-1:0] r_rec_addr, r_fwd_addr;
  logic [DATA_W-1:0] r_rec_data, r_fwd_data;

  assign w_fwd_hit      = r_rec_v && !w_head.we && (r_rec_addr == w_head.addr);
  assign w_rsp_addr_sel = r_fwd_pend ? r_fwd_addr : r_rf_addr;
  assign w_rsp_data_sel = r_fwd_pend ? r_fwd_data : rf_read_data;

  // A forwarded read still walks ISSUE then RD_WAIT with both enables low,
  // so its response timing is identical to a real register-file read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rec_v    <= 1'b0;
      r_rec_addr <= '0;
      r_rec_data <= '0;
      r_fwd_pend <= 1'b0;
      r_fwd_addr <= '0;
      r_fwd_data <= '0;
    end else if (flush) begin
      r_rec_v    <= 1'b0;
      r_fwd_pend <= 1'b0;
    end else if (w_pop) begin
      r_fwd_pend <= w_fwd_hit;
      r_fwd_addr <= w_head.addr;
      r_fwd_data <= r_rec_data;
      if (w_head.we) begin
        r_rec_v    <= 1'b1;
        r_rec_addr <= w_head.addr;
        r_rec_data <= w_head.wdata;
      end
    end
  end
`else
  assign w_fwd_hit      = 1'b0;
  assign w_rsp_addr_sel = r_rf_addr;
  assign w_rsp_data_sel = rf_read_data;
`endif
endmodule

// File: tb/tb_reg_req_sched.sv
// Bench for reg_req_sched: register-file stub, transaction-level timing/data model, directed and random traffic.
module tb_reg_req_sched;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush;
  logic              rf_read_en, rf_write_en, busy;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_read_data = '0;
  logic [1:0]        dbg_state;

  reg_req_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_req_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .bus           (bus),
    .rf_read_en    (rf_read_en),
    .rf_write_en   (rf_write_en),
    .rf_addr       (rf_addr),
    .rf_write_data (rf_write_data),
    .rf_read_data  (rf_read_data),
    .busy          (busy),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock / register-file stub ----------------
  always #5 clk = ~clk;

  logic [DATA_W-1:0] rf_mem [16] = '{default: '0};
  always @(posedge clk) begin
    if (rf_write_en) rf_mem[rf_addr] <= rf_write_data;
    if (rf_read_en)  rf_read_data    <= rf_mem[rf_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                issue;
  } req_t;

  req_t              pend_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int                exp_due_q[$];
  logic [DATA_W-1:0] shadow [16] = '{default: '0};

  int                n = 0;
  int                next_free = 0;
  int                last_rd = -10;
  logic              in_push = 1'b0, in_flush = 1'b0, in_we = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              pw_v = 1'b0;
  logic [ADDR_W-1:0] pw_addr = '0;
  logic [DATA_W-1:0] pw_data = '0;
  logic              cur_v = 1'b0, cur_we = 1'b0, rsp_now = 1'b0, fsm_busy = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0, rsp_exp_addr = '0;
  logic [DATA_W-1:0] last_wdata = '0, rsp_exp_data = '0;

  // observation statistics used by the literal pins
  int                n_checks = 0, n_pass = 0;
  int                rsp_cnt = 0, we_cnt = 0, re_cnt = 0, run = 0, max_run = 0;
  logic              saw_full = 1'b0;
  logic [DATA_W-1:0] last_rsp_data = '0;
  logic [ADDR_W-1:0] last_rsp_addr = '0;
  logic [ADDR_W-1:0] wr_addr_q[$];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
  endtask

  // Issue edge of each request = max(accept+1, port free); writes hold the port 1 edge, reads 2.
  task automatic model_step();
    req_t it;
    int   dummy;
    if (pw_v) shadow[pw_addr] = pw_data;
    pw_v = 1'b0; cur_v = 1'b0; rsp_now = 1'b0;
    if (in_flush) begin
      pend_q.delete(); exp_q.delete(); exp_addr_q.delete(); exp_due_q.delete();
      last_rd = -10;
      next_free = n + 1;
    end else if (in_push) begin
      it.we = in_we; it.addr = in_addr; it.data = in_data;
      it.issue = (next_free > n + 1) ? next_free : n + 1;
      next_free = it.issue + (in_we ? 1 : 2);
      pend_q.push_back(it);
    end
    if (pend_q.size() > 0 && pend_q[0].issue == n) begin
      it = pend_q.pop_front();
      cur_v = 1'b1; cur_we = it.we; last_addr = it.addr;
      if (it.we) begin
        last_wdata = it.data;
        pw_v = 1'b1; pw_addr = it.addr; pw_data = it.data;
      end else begin
        exp_q.push_back(shadow[it.addr]);
        exp_addr_q.push_back(it.addr);
        exp_due_q.push_back(n + 2);
        last_rd = n;
      end
    end
    if (exp_due_q.size() > 0 && exp_due_q[0] == n) begin
      rsp_now = 1'b1;
      rsp_exp_data = exp_q.pop_front();
      rsp_exp_addr = exp_addr_q.pop_front();
      dummy = exp_due_q.pop_front();
    end
    fsm_busy = cur_v || (last_rd == n - 1);
  endtask

  task automatic check_outputs();
    check("rf_write_en", {31'd0, rf_write_en}, {31'd0, cur_v && cur_we});
    check("rf_read_en", {31'd0, rf_read_en}, {31'd0, cur_v && !cur_we});
    check("rf_mutex", {31'd0, rf_read_en && rf_write_en}, 32'd0);
    check("rf_addr", {28'd0, rf_addr}, {28'd0, last_addr});
    check("rf_write_data", rf_write_data, last_wdata);
    check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, rsp_now});
    if (rsp_now) begin
      check("rsp_data", bus.rsp_data, rsp_exp_data);
      check("rsp_addr", {28'd0, bus.rsp_addr}, {28'd0, rsp_exp_addr});
    end
    check("busy", {31'd0, busy}, {31'd0, (pend_q.size() > 0) || fsm_busy});
    if (rf_write_en) begin
      we_cnt++; run++; wr_addr_q.push_back(rf_addr);
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (rf_read_en) re_cnt++;
    if (bus.rsp_valid) begin
      rsp_cnt++; last_rsp_data = bus.rsp_data; last_rsp_addr = bus.rsp_addr;
    end
  endtask

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic cycle(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic fl, output logic acc);
    logic exp_ready;
    bus.req_valid = v; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d; flush = fl;
    exp_ready = (pend_q.size() < DEPTH) && !fl;
    if (pend_q.size() == DEPTH) saw_full = 1'b1;
    #1;
    check("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_ready});
    in_push = v && exp_ready; in_we = we; in_addr = a; in_data = d; in_flush = fl;
    acc = in_push;
    @(negedge clk);
    n++;
    model_step();
    check_outputs();
  endtask

  task automatic send(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic acc;
    for (int k = 0; k < 50; k++) begin
      cycle(1'b1, we, a, d, 1'b0, acc);
      if (acc) return;
    end
    n_checks++;
    $display("FAIL send_timeout: request addr %0d not accepted within 50 cycles", a);
  endtask

  task automatic idle(input int k);
    logic acc;
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, acc);
  endtask

  task automatic wait_idle();
    logic acc;
    for (int k = 0; k < 100; k++) begin
      if (pend_q.size() == 0 && !fsm_busy && exp_due_q.size() == 0) break;
      cycle(1'b0, 1'b0, '0, '0, 1'b0, acc);
    end
    if (pend_q.size() != 0 || fsm_busy || exp_due_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: model still busy after 100 cycles");
    end
    check("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic reset_phase(input int k);
    #2;
    rst = 1'b0; bus.req_valid = 1'b1; flush = 1'b0;
    #1;
    check("async_rst_we", {31'd0, rf_write_en}, 32'd0);
    check("async_rst_re", {31'd0, rf_read_en}, 32'd0);
    pend_q.delete(); exp_q.delete(); exp_addr_q.delete(); exp_due_q.delete();
    pw_v = 1'b0; cur_v = 1'b0; rsp_now = 1'b0; fsm_busy = 1'b0;
    last_rd = -10; next_free = 0; last_addr = '0; last_wdata = '0;
    in_push = 1'b0; in_flush = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      n++;
      check("rst_rf_en", {30'd0, rf_read_en, rf_write_en}, 32'd0);
      check("rst_rf_addr", {28'd0, rf_addr}, 32'd0);
      check("rst_rf_wdata", rf_write_data, 32'd0);
      check("rst_rsp", {27'd0, bus.rsp_valid, bus.rsp_addr}, 32'd0);
      check("rst_rsp_data", bus.rsp_data, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    end
    bus.req_valid = 1'b0;
    rst = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int                r0, w0, e0;
    logic [DATA_W-1:0] d;
    logic              hv, hwe, acc, fl;
    logic [ADDR_W-1:0] ha;
    logic [DATA_W-1:0] hd;
    int                pval;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    flush = 1'b0;
    @(negedge clk);
    reset_phase(3);
    idle(4);
    check("post_rst_no_enables", we_cnt + re_cnt, 32'd0);

    // write then read of address 0
    r0 = rsp_cnt; w0 = we_cnt;
    send(1'b1, 4'd0, 32'h43211234);
    send(1'b0, 4'd0, '0);
    wait_idle();
    check("wr_rd_rsp_cnt", rsp_cnt - r0, 32'd1);
    check("wr_rd_we_cnt", we_cnt - w0, 32'd1);
    check("wr_rd_data", last_rsp_data, 32'h43211234);
    check("wr_rd_addr", {28'd0, last_rsp_addr}, 32'd0);

    // three reads stall the port so five writes fill the FIFO
    wr_addr_q.delete(); max_run = 0; saw_full = 1'b0;
    send(1'b0, 4'd6, '0); send(1'b0, 4'd7, '0); send(1'b0, 4'd8, '0);
    for (int a = 1; a <= 5; a++) send(1'b1, 4'(a), 32'hA000_0000 + 32'(a));
    wait_idle();
    check("fill_saw_full", {31'd0, saw_full}, 32'd1);
    check("fill_max_run", max_run, 32'd5);
    check("fill_wr_cnt", wr_addr_q.size(), 32'd5);
    for (int i = 0; i < 5 && i < wr_addr_q.size(); i++)
      check("fill_wr_addr", {28'd0, wr_addr_q[i]}, 32'(i + 1));

    // alternating write/read over all addresses
    r0 = rsp_cnt; e0 = re_cnt; d = '0;
    for (int a = 0; a < 16; a++) begin
      d = d + 32'h48791234;
      send(1'b1, 4'(a), d);
      send(1'b0, 4'(a), '0);
    end
    wait_idle();
    check("ilv_rsp_cnt", rsp_cnt - r0, 32'd16);
    check("ilv_re_cnt", re_cnt - e0, 32'd16);
    check("ilv_last_data", last_rsp_data, 32'h87912340);
    check("ilv_last_addr", {28'd0, last_rsp_addr}, 32'd15);

    // flush while a read sits in RD_WAIT with two writes queued
    r0 = rsp_cnt; w0 = we_cnt;
    send(1'b0, 4'd3, '0);
    send(1'b1, 4'd4, 32'hDEAD0004);
    send(1'b1, 4'd5, 32'hDEAD0005);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("flush_busy", {31'd0, busy}, 32'd0);
    idle(6);
    check("flush_no_rsp", rsp_cnt - r0, 32'd0);
    check("flush_no_issue", we_cnt - w0, 32'd0);

    // reset while a write is on the port and more are queued
    send(1'b1, 4'd9, 32'h11110009);
    send(1'b1, 4'd10, 32'h1111000A);
    send(1'b1, 4'd11, 32'h1111000B);
    check("pre_rst_we", {31'd0, rf_write_en}, 32'd1);
    w0 = we_cnt;
    reset_phase(2);
    idle(5);
    check("rst_fifo_empty", {31'd0, busy}, 32'd0);
    check("rst_no_issue", we_cnt - w0, 32'd0);

    // randomized traffic with held requests and occasional flush
    hv = 1'b0; hwe = 1'b0; ha = '0; hd = '0;
    for (int i = 0; i < 2400; i++) begin
      pval = (i < 800) ? 30 : (i < 1600) ? 90 : 60;
      if (!hv && ($urandom_range(0, 99) < pval)) begin
        hv = 1'b1;
        hwe = 1'($urandom_range(0, 1));
        ha = 4'($urandom_range(0, 7));
        hd = $urandom;
      end
      fl = ($urandom_range(0, 99) < 2);
      cycle(hv, hwe, ha, hd, fl, acc);
      if (acc) hv = 1'b0;
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/reg_req_sched.md
# reg_req_sched

Request scheduler that sits directly upstream of the 16 x 32-bit register file (`REG_32`) and is the only block allowed to drive its read/write port. Producers enqueue read/write requests through a valid/ready handshake into a small FIFO. The scheduler serialises these requests onto the register file's `read_en`/`write_en`/`addr`/`write_data` port and returns read data with a response strobe. It guarantees that the register file never sees `read_en` and `write_en` asserted together, and that requests are executed in acceptance order.

## Interface
- `DATA_W`, 32, data width; must match the register file.
- `ADDR_W`, 4, register address width (16 registers).
- `DEPTH`, 4, request FIFO depth; must be a power of two and at least 2.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear: drop all queued and in-flight requests.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  `!full && !flush`, combinational.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  target register.
- `req_wdata`  in  DATA_W  write data; ignored for reads.
- `rf_read_en`  out  1  to register file `read_en`; registered.
- `rf_write_en`  out  1  to register file `write_en`; registered.
- `rf_addr`  out  ADDR_W  to register file `addr`; registered.
- `rf_write_data`  out  DATA_W  to register file `write_data`; registered.
- `rf_read_data`  in  DATA_W  from register file `read_data`; valid one cycle after `rf_read_en`.
- `rsp_valid`  out  1  one-cycle read-response strobe.
- `rsp_addr`  out  ADDR_W  address of the returned read.
- `rsp_data`  out  DATA_W  read data.
- `busy`  out  1  FIFO non-empty, or FSM not in IDLE.

## Operation
- **Request FIFO:**
  - Circular buffer of {we, addr, wdata}, `DEPTH` entries.
  - Pointers are `log2(DEPTH)` bits wide and wrap modulo `DEPTH`.
  - The count is `log2(DEPTH)+1` bits wide.
  - A push happens on `req_valid && req_ready`.
  - A pop happens when the FSM issues an entry.
  - Push and pop in the same cycle leave the count unchanged. This is legal when full (`req_ready` is low, so no push occurs) and when empty (no pop occurs).
- **FSM states:** IDLE, ISSUE, RD_WAIT.
  - **IDLE:** if the FIFO is non-empty, pop the head, register it onto the `rf_*` outputs with the matching enable high, and go to ISSUE. Otherwise all enables stay low.
  - **ISSUE (write):** the enable is high for this cycle only. If the FIFO is non-empty, pop the next entry and stay in ISSUE, giving back-to-back writes at one per cycle. Otherwise go to IDLE.
  - **ISSUE (read):** drop `rf_read_en` and go to RD_WAIT. No pop happens in this cycle.
  - **RD_WAIT:** capture `rf_read_data` into `rsp_data` and `rf_addr` into `rsp_addr`, pulse `rsp_valid`, then behave as IDLE for the next pop in this same cycle. A read therefore occupies the port for 2 cycles.
- **Mutual exclusion:** `rf_read_en` and `rf_write_en` are never both 1.
- **Data held when idle:** `rf_addr` and `rf_write_data` hold their last value while both enables are low.
- **flush:** clears the count and pointers and forces IDLE with both enables low. A read in RD_WAIT is discarded and no `rsp_valid` is produced. Flush wins over a simultaneous push, because `req_ready` is low.
- **Reset values (while `rst` = 0):**
  - All `rf_*` outputs 0, `rsp_valid` 0, `rsp_addr` 0, `rsp_data` 0.
  - FIFO empty, FSM in IDLE, `busy` 0.
  - `req_ready` is 1 whenever `flush` is 0.
- **Reset mid-operation:** any queued or in-flight request is lost and no response is generated.

## Timing
- A request accepted at edge E0 drives its `rf_*` enable from edge E1, provided the FIFO was empty and the FSM was IDLE.
- For a read, `rsp_valid` is high for the cycle after edge E3. The read latency from acceptance to response is 3 edges.
- Sustained throughput: 1 write per cycle; 1 read per 2 cycles.
- For a write accepted at E0, the register file updates at E2. A subsequent read of the same address therefore returns the new value.

## Configuration
- **`REG_REQ_FWD_EN` defined:**
  - The scheduler keeps a last-write record {valid, addr, data}, updated on every issued write and cleared by `flush` or reset.
  - A read popped from IDLE or ISSUE whose address matches a valid record is not issued to the register file (`rf_read_en` stays low).
  - Instead, the scheduler goes to RD_WAIT and responds with the record data. The latency is unchanged, but the register-file port is free.
- **`REG_REQ_FWD_EN` undefined:** every read is issued to the register file, and no record logic exists.

## Test plan
- **Reset:** hold `rst` = 0 with `req_valid` = 1.
  - Required: all outputs 0 except `req_ready` = 1.
  - Required: no enable pulses after reset release, with an empty FIFO.
- **Write then read:** write 0x43211234 to addr 0, then read addr 0.
  - Required: `rf_write_en` for 1 cycle with addr 0.
  - Required: then `rsp_valid` with `rsp_data` = 0x43211234 and `rsp_addr` = 0.
  - With `REG_REQ_FWD_EN` defined, `rf_read_en` stays 0.
- **Fill and back-pressure:** push 5 writes back-to-back to addrs 1..5 with `DEPTH` = 4.
  - Required: `req_ready` drops while the FIFO is full.
  - Required: `rf_write_en` stays high for 5 consecutive cycles with addrs 1..5 in order.
  - Required: enables are never both high.
- **Interleaved reads:** alternate write and read to addrs 0..15 with data incremented by 0x48791234.
  - Required: each read returns the value written, in order.
  - Required: each read occupies the port for 2 cycles.
- **Flush in RD_WAIT:** assert `flush` while a read is in RD_WAIT and 2 requests are queued.
  - Required: no `rsp_valid`, `busy` = 0 next cycle, and the queued requests are never issued.
- **Reset mid-operation:** pull `rst` low during ISSUE of a write.
  - Required: enables drop immediately (asynchronously).
  - Required: the FIFO is empty after release.
